mem_port_arbiter: RTL and testbench

Arbitrates the single physical memory port between the instruction-fetch requester and the load/store requester of the RV32I core. Each granted transaction's address, data and mask are latched and held on the memory port until `mem_resp`, which is routed back to the owning requester as a one-cycle response pulse. Data accesses normally win. A streak counter guarantees fetch is never starved.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-port signal bundle for the
//               RV32I memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;

  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // Arbiter side
  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata, d_wmask,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );

  // Requester / memory side
  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata, d_wmask,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and
//               load/store; data wins, a streak counter bounds fetch wait.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] C_STREAK_MAX = 4'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_streak;
  logic [3:0]  w_streak_nxt;
  logic        w_d_req;
  logic        w_grant_i;
  logic        w_grant_d;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_op_write;

  assign w_d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!bus.i_read || (r_streak < C_STREAK_MAX))) begin
          w_grant_d = 1'b1;
        end else if (bus.i_read) begin
          w_grant_i = 1'b1;
        end

        if (w_grant_d) begin
          w_state_nxt = SERVE_D;
          // A data win with fetch waiting only happens below the limit,
          // so the increment can never pass STREAK_MAX.
          w_streak_nxt = bus.i_read ? (r_streak + 4'd1) : 4'd0;
        end else if (w_grant_i) begin
          w_state_nxt  = SERVE_I;
          w_streak_nxt = 4'd0;
        end else begin
          w_streak_nxt = 4'd0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Port registers: captured once at grant, requester inputs ignored after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wmask    <= 4'd0;
      r_op_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr     <= bus.d_addr;
      r_wdata    <= bus.d_wdata;
      r_wmask    <= bus.d_wmask;
      r_op_write <= bus.d_write;
    end else if (w_grant_i) begin
      r_addr     <= bus.i_addr;
      r_wmask    <= 4'd0;
      r_op_write <= 1'b0;
    end
  end

  assign bus.mem_read  = (r_state != IDLE) && !r_op_write;
  assign bus.mem_write = (r_state != IDLE) &&  r_op_write;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wmask = r_wmask;

  assign bus.i_resp  = (r_state == SERVE_I) && bus.mem_resp;
  assign bus.d_resp  = (r_state == SERVE_D) && bus.mem_resp;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized requesters and memory with a scoreboard and an
//               arbitration reference for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int          C_STREAK_MAX = 4;
  localparam logic [31:0] C_RD_KEY     = 32'h0000_0073;
  localparam byte         C_GD         = "D";
  localparam byte         C_GI         = "I";

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STREAK_MAX(C_STREAK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  m;
  } dexp_t;

  dexp_t       exp_d[$];
  logic [31:0] exp_i[$];
  byte         order[$];

  int n_chk = 0;
  int n_fail = 0;
  int lat_lo = 1;
  int lat_hi = 4;
  int cur_lat = 1;
  int m_cnt = 0;
  int d_cnt = 0;

  logic        m_resp = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  assign bus.mem_rdata = m_rdata;
  assign bus.mem_resp  = m_resp | stray;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %08h required %08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual no event required event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: answers on the cur_lat-th strobe cycle; read data is address-keyed.
  initial begin
    forever begin
      tick();
      if (!rst_n || m_resp) begin
        m_resp = 1'b0;
        m_cnt  = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        if (m_cnt == 0) cur_lat = int'($urandom_range(lat_hi, lat_lo));
        m_cnt++;
        if (m_cnt >= cur_lat) begin
          m_resp  = 1'b1;
          m_rdata = bus.mem_addr ^ C_RD_KEY;
        end
      end else begin
        m_rdata = $urandom;
      end
    end
  end

  // Monitor: arbitration reference plus response scoreboard.
  logic        g_valid = 1'b0;
  logic        g_prev_idle = 1'b0;
  logic        p_i = 1'b0, p_d = 1'b0, p_dw = 1'b0;
  logic [31:0] p_ia = '0, p_da = '0, p_dwd = '0;
  logic [3:0]  p_dm = '0;
  logic [31:0] last_wd = '0;
  int          data_wins_while_fetch_waits = 0;
  int          w_cnt = 0;
  logic        prev_ir = 1'b0, prev_dr = 1'b0;

  always @(negedge clk) begin
    logic        strobe;
    logic [31:0] a;
    dexp_t       e;
    strobe = bus.mem_read | bus.mem_write;
    if (!rst_n) begin
      g_valid = 1'b0;
      data_wins_while_fetch_waits = 0;
      last_wd = '0;
      w_cnt   = 0;
      prev_ir = 1'b0;
      prev_dr = 1'b0;
    end else begin
      w_cnt = strobe ? w_cnt + 1 : 0;
      if (g_valid && g_prev_idle) begin
        if (strobe) begin
          if (p_d && (!p_i || data_wins_while_fetch_waits < C_STREAK_MAX)) begin
            order.push_back(C_GD);
            chk("grant_d_addr", bus.mem_addr, p_da);
            chk("grant_d_wdata", bus.mem_wdata, p_dwd);
            chk("grant_d_wmask", {28'd0, bus.mem_wmask}, {28'd0, p_dm});
            chkb("grant_d_write", bus.mem_write, p_dw);
            chkb("grant_d_read", bus.mem_read, !p_dw);
            data_wins_while_fetch_waits = p_i ? data_wins_while_fetch_waits + 1 : 0;
            last_wd = p_dwd;
          end else if (p_i) begin
            order.push_back(C_GI);
            chk("grant_i_addr", bus.mem_addr, p_ia);
            chk("grant_i_wdata_held", bus.mem_wdata, last_wd);
            chk("grant_i_wmask", {28'd0, bus.mem_wmask}, 32'd0);
            chkb("grant_i_read", bus.mem_read, 1'b1);
            data_wins_while_fetch_waits = 0;
          end else begin
            fail("grant_without_request");
          end
        end else begin
          chkb("idle_with_request", p_i | p_d, 1'b0);
          data_wins_while_fetch_waits = 0;
        end
      end
      if (prev_ir || prev_dr) chkb("idle_after_resp", strobe, 1'b0);
      if (bus.i_resp || bus.d_resp) chkb("resp_exclusive", bus.i_resp & bus.d_resp, 1'b0);
      if (bus.i_resp) begin
        chkb("i_resp_one_cycle", prev_ir, 1'b0);
        if (exp_i.size() == 0) begin
          fail("unexpected_i_resp");
        end else begin
          a = exp_i.pop_front();
          chk("i_rdata", bus.i_rdata, a ^ C_RD_KEY);
          chk("i_mem_addr", bus.mem_addr, a);
          chkb("i_mem_read", bus.mem_read, 1'b1);
          chk("i_strobe_cycles", w_cnt, cur_lat);
        end
      end
      if (bus.d_resp) begin
        d_cnt++;
        chkb("d_resp_one_cycle", prev_dr, 1'b0);
        if (exp_d.size() == 0) begin
          fail("unexpected_d_resp");
        end else begin
          e = exp_d.pop_front();
          chk("d_mem_addr", bus.mem_addr, e.a);
          chkb("d_mem_write", bus.mem_write, e.wr);
          chkb("d_mem_read", bus.mem_read, !e.wr);
          if (e.wr) begin
            chk("d_mem_wdata", bus.mem_wdata, e.wd);
            chk("d_mem_wmask", {28'd0, bus.mem_wmask}, {28'd0, e.m});
          end else begin
            chk("d_rdata", bus.d_rdata, e.a ^ C_RD_KEY);
          end
          chk("d_strobe_cycles", w_cnt, cur_lat);
        end
      end
      prev_ir     = bus.i_resp;
      prev_dr     = bus.d_resp;
      g_valid     = 1'b1;
      g_prev_idle = !strobe;
      p_i   = bus.i_read;
      p_d   = bus.d_read | bus.d_write;
      p_dw  = bus.d_write;
      p_ia  = bus.i_addr;
      p_da  = bus.d_addr;
      p_dwd = bus.d_wdata;
      p_dm  = bus.d_wmask;
    end
  end

  task automatic issue_i(input logic [31:0] a);
    bus.i_read = 1'b1;
    bus.i_addr = a;
    exp_i.push_back(a);
  endtask

  task automatic issue_d(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
    bus.d_write = wr;
    bus.d_read  = rd;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wmask = m;
    exp_d.push_back('{wr, a, wd, m});
  endtask

  task automatic wait_i_done();
    int t;
    t = 0;
    while (exp_i.size() != 0 && t < 400) begin tick(); t++; end
    if (exp_i.size() != 0) fail("i_resp_timeout");
  endtask

  task automatic wait_d_done();
    int t;
    t = 0;
    while (exp_d.size() != 0 && t < 400) begin tick(); t++; end
    if (exp_d.size() != 0) fail("d_resp_timeout");
  endtask

  task automatic wait_strobe();
    int t;
    t = 0;
    while (!(bus.mem_read || bus.mem_write) && t < 50) begin tick(); t++; end
    if (!(bus.mem_read || bus.mem_write)) fail("strobe_timeout");
  endtask

  task automatic fetch_agent(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      issue_i($urandom & 32'hFFFF_FFFC);
      wait_i_done();
      bus.i_read = 1'b0;
    end
  endtask

  task automatic data_agent(input int n, input int max_gap);
    int kind;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      kind = int'($urandom_range(7, 0));
      issue_d((kind < 3) || (kind == 7), kind >= 3, $urandom & 32'hFFFF_FFFC,
              $urandom, 4'($urandom));
      wait_d_done();
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wmask = '0;

    tick();
    chkb("rst_mem_read", bus.mem_read, 1'b0);
    chkb("rst_mem_write", bus.mem_write, 1'b0);
    chkb("rst_i_resp", bus.i_resp, 1'b0);
    chkb("rst_d_resp", bus.d_resp, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Random traffic from both requesters.
    lat_lo = 1; lat_hi = 4;
    fork
      fetch_agent(25, 3);
      data_agent(35, 2);
    join
    repeat (3) tick();

    // Lone fetch, memory latency 3.
    lat_lo = 3; lat_hi = 3;
    d0 = d_cnt;
    issue_i(32'h0000_0060);
    wait_i_done();
    bus.i_read = 1'b0;
    chk("lone_fetch_no_d_resp", d_cnt, d0);
    repeat (2) tick();

    // Store whose inputs change after the grant.
    lat_lo = 2; lat_hi = 2;
    issue_d(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hC);
    wait_strobe();
    bus.d_addr  = 32'h0BAD_0000;
    bus.d_wdata = 32'h0000_0000;
    bus.d_wmask = 4'hF;
    wait_d_done();
    bus.d_write = 1'b0;
    repeat (2) tick();

    // Load that deasserts mid-transaction.
    lat_lo = 4; lat_hi = 4;
    issue_d(1'b0, 1'b1, 32'h0000_0444, 32'h0, 4'h0);
    wait_strobe();
    tick();
    bus.d_read = 1'b0;
    wait_d_done();
    chkb("deassert_idle_follows", bus.mem_read | bus.mem_write, 1'b0);
    repeat (2) tick();

    // Async reset in the middle of a data transaction.
    lat_lo = 6; lat_hi = 6;
    issue_d(1'b0, 1'b1, 32'h0000_0888, 32'h0, 4'h0);
    wait_strobe();
    issue_i(32'h0000_0ABC);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chkb("async_rst_mem_read", bus.mem_read, 1'b0);
    chkb("async_rst_mem_write", bus.mem_write, 1'b0);
    chkb("async_rst_d_resp", bus.d_resp, 1'b0);
    exp_d.delete();
    bus.d_read = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    lat_lo = 1; lat_hi = 2;
    wait_i_done();
    bus.i_read = 1'b0;
    repeat (2) tick();

    // Continuous contention, memory latency 1.
    lat_lo = 1; lat_hi = 1;
    order.delete();
    fork
      fetch_agent(2, 0);
      data_agent(8, 0);
    join
    chk("contention_grant_count", order.size(), 10);
    for (int k = 0; k < 10 && k < order.size(); k++) begin
      chk($sformatf("contention_grant_%0d", k), {24'd0, order[k]},
          {24'd0, ((k % (C_STREAK_MAX + 1)) == C_STREAK_MAX) ? C_GI : C_GD});
    end
    repeat (2) tick();

    // Stray memory response in IDLE, then a read+write dual request.
    stray = 1'b1;
    @(negedge clk);
    chkb("stray_i_resp", bus.i_resp, 1'b0);
    chkb("stray_d_resp", bus.d_resp, 1'b0);
    tick();
    stray = 1'b0;
    chkb("stray_no_strobe", bus.mem_read | bus.mem_write, 1'b0);
    lat_lo = 2; lat_hi = 2;
    issue_d(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3);
    wait_strobe();
    chkb("dual_is_write", bus.mem_write, 1'b1);
    chkb("dual_no_read", bus.mem_read, 1'b0);
    wait_d_done();
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
